// File: rtl/uart_tx_scheduler_if.sv
// Bundle of the requester-side and sender-side signals of uart_tx_scheduler.
//   req/req_data  : per-requester frame request (level) and packed data words
//   ack/err       : one-cycle completion / start-timeout pulses per requester
//   tx_data/tx_new_data/tx_busy : link to the shared serial sender
//   grant_id/active             : index of the requester in service, busy flag
// The scheduler connects through the slave modport; the requesters and the
// sender (or a bench standing in for them) use the master modport.
interface uart_tx_scheduler_if #(
  parameter int NREQ = 4,
  parameter int DW   = 7,
  parameter int IW   = 2
);
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    ack;
  logic [NREQ-1:0]    err;
  logic [DW-1:0]      tx_data;
  logic               tx_new_data;
  logic               tx_busy;
  logic [IW-1:0]      grant_id;
  logic               active;

  modport master (
    output req, req_data, tx_busy,
    input  ack, err, tx_data, tx_new_data, grant_id, active
  );

  modport slave (
    input  req, req_data, tx_busy,
    output ack, err, tx_data, tx_new_data, grant_id, active
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one serial sender between NREQ requesters.
// A granted frame is presented on tx_data with tx_new_data held high until the
// sender raises tx_busy; when busy falls the requester gets a one-cycle ack.
// If busy never rises within START_TIMEOUT cycles the requester gets an err.
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : uart_tx_scheduler_if slave modport (req, req_data, tx_busy in;
//         ack, err, tx_data, tx_new_data, grant_id, active out)
// All outputs are registered.
module uart_tx_scheduler #(
  parameter int NREQ          = 4,
  parameter int DW            = 7,
  parameter int IW            = 2,
  parameter int START_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_tx_scheduler_if.slave   bus
);

  localparam int CW = $clog2(START_TIMEOUT);
  localparam int SW = IW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_SEND
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   last_q, last_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [NREQ-1:0] err_q, err_d;
  logic [DW-1:0]   data_q, data_d;
  logic            new_q, new_d;
  logic            active_q, active_d;

  logic            found;
  logic [IW-1:0]   pick;
  logic [SW-1:0]   scan;

  // Round-robin pick: first set req bit starting one past the last served
  // requester. last+k never exceeds 2*NREQ-1, so a single conditional
  // subtraction replaces the modulo.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    scan  = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      scan = SW'(last_q) + SW'(k);
      if (scan >= SW'(NREQ)) scan = scan - SW'(NREQ);
      if (!found && bus.req[scan[IW-1:0]]) begin
        found = 1'b1;
        pick  = scan[IW-1:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    grant_d  = grant_q;
    cnt_d    = cnt_q;
    ack_d    = '0;
    err_d    = '0;
    data_d   = data_q;
    new_d    = new_q;
    active_d = active_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d  = pick;
          data_d   = bus.req_data[pick*DW +: DW];
          active_d = 1'b1;
          new_d    = 1'b1;
          cnt_d    = '0;
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + CW'(1);
        // busy on the final cycle still counts as a successful start
        if (bus.tx_busy) begin
          new_d   = 1'b0;
          state_d = S_SEND;
        end else if (cnt_q == CW'(START_TIMEOUT - 1)) begin
          new_d          = 1'b0;
          active_d       = 1'b0;
          err_d[grant_q] = 1'b1;
          last_d         = grant_q;
          state_d        = S_IDLE;
        end
      end
      S_SEND: begin
        if (!bus.tx_busy) begin
          ack_d[grant_q] = 1'b1;
          active_d       = 1'b0;
          last_d         = grant_q;
          state_d        = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      last_q   <= IW'(NREQ - 1);
      grant_q  <= '0;
      cnt_q    <= '0;
      ack_q    <= '0;
      err_q    <= '0;
      data_q   <= '0;
      new_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      data_q   <= data_d;
      new_q    <= new_d;
      active_q <= active_d;
    end
  end

  assign bus.ack         = ack_q;
  assign bus.err         = err_q;
  assign bus.tx_data     = data_q;
  assign bus.tx_new_data = new_q;
  assign bus.grant_id    = grant_q;
  assign bus.active      = active_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
module tb_uart_tx_scheduler;

  localparam int NREQ = 4;
  localparam int DW   = 7;
  localparam int IW   = 2;
  localparam int TMO  = 16;
  localparam logic [NREQ*DW-1:0] D0 = {7'h13, 7'h12, 7'h11, 7'h10};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_scheduler_if #(.NREQ(NREQ), .DW(DW), .IW(IW)) bus();

  uart_tx_scheduler #(
    .NREQ(NREQ), .DW(DW), .IW(IW), .START_TIMEOUT(TMO)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Sender stand-in: raises busy snd_delay cycles after seeing tx_new_data
  // (0 = never) and holds it snd_len cycles.
  int snd_delay = 0, snd_len = 1, snd_phase = 0, snd_cnt = 0;

  typedef struct {
    logic [NREQ-1:0]    r;
    logic [NREQ*DW-1:0] data;
    int                 d;
    int                 len;
    logic [IW-1:0]      exp_g;
    logic [DW-1:0]      exp_d;
    int                 exp_nd;
    logic [NREQ-1:0]    exp_ack;
    logic [NREQ-1:0]    exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sender_step();
    if (rst) begin
      snd_phase   = 0;
      snd_cnt     = 0;
      bus.tx_busy = 1'b0;
    end else begin
      case (snd_phase)
        0: if (bus.tx_new_data && snd_delay > 0) begin
             if (snd_delay == 1) begin
               bus.tx_busy = 1'b1; snd_cnt = 0; snd_phase = 2;
             end else begin
               snd_cnt = 1; snd_phase = 1;
             end
           end
        1: begin
             snd_cnt++;
             if (snd_cnt == snd_delay) begin
               bus.tx_busy = 1'b1; snd_cnt = 0; snd_phase = 2;
             end
           end
        2: begin
             snd_cnt++;
             if (snd_cnt >= snd_len) begin
               bus.tx_busy = 1'b0; snd_phase = 0;
             end
           end
        default: snd_phase = 0;
      endcase
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sender_step();
  endtask

  // Drives one request set and observes until ack or err appears.
  task automatic do_frame(
    input  logic [NREQ-1:0]    r,
    input  logic [NREQ*DW-1:0] data,
    input  int                 d,
    input  int                 len,
    output logic               first_nd,
    output logic [IW-1:0]      g,
    output logic [DW-1:0]      td,
    output logic [DW-1:0]      td_end,
    output int                 nd,
    output logic [NREQ-1:0]    a,
    output logic [NREQ-1:0]    e,
    output logic               act_end
  );
    bit seen;
    bus.req = r; bus.req_data = data; snd_delay = d; snd_len = len;
    seen = 0; nd = 0; g = '0; td = '0; td_end = '0; a = '0; e = '0;
    act_end = 1'b1; first_nd = 1'b0;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (c == 0) first_nd = bus.tx_new_data;
      if (bus.tx_new_data) begin
        nd++;
        if (!seen) begin seen = 1; g = bus.grant_id; td = bus.tx_data; end
      end
      if ((bus.ack | bus.err) != '0) begin
        a = bus.ack; e = bus.err; td_end = bus.tx_data; act_end = bus.active;
        return;
      end
    end
    n_tests++; n_fail++;
    $display("FAIL frame_wait: no ack/err within 200 cycles, expected one");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic               fnd, act_e;
    logic [IW-1:0]      g;
    logic [DW-1:0]      td, tde;
    int                 nd;
    logic [NREQ-1:0]    a, e;
    logic [NREQ-1:0]    pend;
    logic [DW-1:0]      dm[NREQ];
    logic [NREQ*DW-1:0] pk;
    int                 last_m, eg, d, rr;
    bit                 changed, done;

    vecs[0] = '{4'b0001, {7'h13, 7'h12, 7'h11, 7'b1011001}, 2, 20, 2'd0, 7'b1011001, 2, 4'b0001, 4'b0000};
    vecs[1] = '{4'b0110, D0, 1, 3, 2'd1, 7'h11, 1, 4'b0010, 4'b0000};
    vecs[2] = '{4'b0100, D0, 0, 1, 2'd2, 7'h12, TMO, 4'b0000, 4'b0100};
    vecs[3] = '{4'b1001, D0, 16, 2, 2'd3, 7'h13, 16, 4'b1000, 4'b0000};
    vecs[4] = '{4'b1001, D0, 3, 1, 2'd0, 7'h10, 3, 4'b0001, 4'b0000};
    vecs[5] = '{4'b1000, D0, 5, 4, 2'd3, 7'h13, 5, 4'b1000, 4'b0000};
    vecs[6] = '{4'b0011, D0, 1, 1, 2'd0, 7'h10, 1, 4'b0001, 4'b0000};
    vecs[7] = '{4'b1110, D0, 15, 2, 2'd1, 7'h11, 15, 4'b0010, 4'b0000};
    vecs[8] = '{4'b1100, {7'h7F, 7'h00, 7'h2A, 7'h55}, 2, 1, 2'd2, 7'h00, 2, 4'b0100, 4'b0000};
    vecs[9] = '{4'b1000, {7'h7F, 7'h00, 7'h2A, 7'h55}, 0, 1, 2'd3, 7'h7F, TMO, 4'b0000, 4'b1000};

    rst = 1'b1; bus.req = '0; bus.req_data = '0; bus.tx_busy = 1'b0;
    tick(); tick();
    check("rst_ack", bus.ack, 0);
    check("rst_err", bus.err, 0);
    check("rst_tx_data", bus.tx_data, 0);
    check("rst_tx_new_data", bus.tx_new_data, 0);
    check("rst_grant_id", bus.grant_id, 0);
    check("rst_active", bus.active, 0);
    rst = 1'b0;
    tick();

    // Table-driven single frames; pointer state carries from row to row.
    for (int i = 0; i < 10; i++) begin
      do_frame(vecs[i].r, vecs[i].data, vecs[i].d, vecs[i].len, fnd, g, td, tde, nd, a, e, act_e);
      check($sformatf("v%0d_latency", i), fnd, 1);
      check($sformatf("v%0d_grant", i), g, vecs[i].exp_g);
      check($sformatf("v%0d_data", i), td, vecs[i].exp_d);
      check($sformatf("v%0d_data_end", i), tde, vecs[i].exp_d);
      check($sformatf("v%0d_new_cycles", i), nd, vecs[i].exp_nd);
      check($sformatf("v%0d_ack", i), a, vecs[i].exp_ack);
      check($sformatf("v%0d_err", i), e, vecs[i].exp_err);
      check($sformatf("v%0d_active_end", i), act_e, 0);
      bus.req = '0;
      tick();
      check($sformatf("v%0d_pulse_width", i), {bus.ack, bus.err}, 0);
      check($sformatf("v%0d_idle_new", i), bus.tx_new_data, 0);
      check($sformatf("v%0d_hold_grant", i), bus.grant_id, vecs[i].exp_g);
      check($sformatf("v%0d_hold_data", i), bus.tx_data, vecs[i].exp_d);
    end

    // Round-robin with every request held: 0,1,2,3,0.
    for (int f = 0; f < 5; f++) begin
      do_frame(4'b1111, D0, 2, 3, fnd, g, td, tde, nd, a, e, act_e);
      check($sformatf("rr%0d_one_idle", f), fnd, 1);
      check($sformatf("rr%0d_grant", f), g, f % 4);
      check($sformatf("rr%0d_data", f), td, 7'h10 + (f % 4));
      check($sformatf("rr%0d_ack", f), a, 1 << (f % 4));
      check($sformatf("rr%0d_err", f), e, 0);
    end
    bus.req = '0;
    tick();

    // Data and req changes after grant are ignored.
    bus.req = 4'b0100; bus.req_data = {7'h13, 7'h2A, 7'h11, 7'h10};
    snd_delay = 2; snd_len = 6; changed = 0; done = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      tick();
      if ((bus.ack | bus.err) != '0) begin
        done = 1;
        check("mid_ack", bus.ack, 4'b0100);
        check("mid_err", bus.err, 0);
        check("mid_tx_data", bus.tx_data, 7'h2A);
        check("mid_grant", bus.grant_id, 2);
      end else if (!changed && bus.tx_busy) begin
        changed = 1;
        bus.req = '0;
        bus.req_data = {4{7'h55}};
      end
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL mid_wait: no ack/err within 100 cycles, expected ack");
    end
    tick();
    check("mid_no_regrant", bus.tx_new_data, 0);

    // Reset while the sender is busy.
    bus.req = 4'b0001; bus.req_data = D0; snd_delay = 1; snd_len = 30;
    for (int c = 0; c < 5; c++) tick();
    check("pre_rst_active", bus.active, 1);
    rst = 1'b1;
    tick();
    check("mid_rst_ack", bus.ack, 0);
    check("mid_rst_err", bus.err, 0);
    check("mid_rst_tx_data", bus.tx_data, 0);
    check("mid_rst_tx_new_data", bus.tx_new_data, 0);
    check("mid_rst_grant", bus.grant_id, 0);
    check("mid_rst_active", bus.active, 0);
    rst = 1'b0; bus.req = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("post_rst_quiet%0d", c), {bus.ack, bus.err, bus.active}, 0);
    end
    do_frame(4'b0010, D0, 2, 2, fnd, g, td, tde, nd, a, e, act_e);
    check("post_rst_grant", g, 1);
    check("post_rst_ack", a, 4'b0010);
    bus.req = '0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    do_frame(4'b1001, D0, 1, 1, fnd, g, td, tde, nd, a, e, act_e);
    check("rst_pointer_grant", g, 0);
    bus.req = '0;
    tick();

    // Randomized traffic against a transaction-level round-robin model.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    last_m = NREQ - 1;
    pend = '0;
    for (int i = 0; i < NREQ; i++) dm[i] = DW'($urandom);
    for (int it = 0; it < 60; it++) begin
      pend = pend | NREQ'($urandom_range(0, (1 << NREQ) - 1));
      if (pend == '0) pend[$urandom_range(0, NREQ - 1)] = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 1) == 1) dm[i] = DW'($urandom);
        pk[i*DW +: DW] = dm[i];
      end
      eg = 0;
      for (int k = NREQ; k >= 1; k--)
        if (pend[(last_m + k) % NREQ]) eg = (last_m + k) % NREQ;
      rr = $urandom_range(0, 9);
      d  = (rr == 0) ? 0 : (rr == 9) ? TMO : rr;
      do_frame(pend, pk, d, $urandom_range(1, 5), fnd, g, td, tde, nd, a, e, act_e);
      check($sformatf("rnd%0d_latency", it), fnd, 1);
      check($sformatf("rnd%0d_grant", it), g, eg);
      check($sformatf("rnd%0d_data", it), td, dm[eg]);
      check($sformatf("rnd%0d_data_end", it), tde, dm[eg]);
      check($sformatf("rnd%0d_new_cycles", it), nd, (d == 0) ? TMO : d);
      check($sformatf("rnd%0d_ack", it), a, (d == 0) ? 0 : (1 << eg));
      check($sformatf("rnd%0d_err", it), e, (d == 0) ? (1 << eg) : 0);
      check($sformatf("rnd%0d_active_end", it), act_e, 0);
      last_m = eg;
      if ($urandom_range(0, 1) == 1) pend[eg] = 1'b0;
    end
    bus.req = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
